// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 OPq ALU family: function codes and the
// architectural condition-code record.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Combinational Y86 OPq datapath: add/sub/and/xor with signed-overflow
// detection and an error flag for function codes 4..7.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]       fn_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] r_o,
    output logic             ofw_o,
    output logic             err_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = p_i + q_i;
    assign diff = p_i - q_i;

    always_comb begin
        r_o   = '0;
        ofw_o = 1'b0;
        err_o = 1'b0;
        case (fn_i)
            ALU_ADD: begin
                r_o   = sum;
                ofw_o = (p_i[MSB] == q_i[MSB]) && (sum[MSB] != p_i[MSB]);
            end
            ALU_SUB: begin
                r_o   = diff;
                ofw_o = (p_i[MSB] != q_i[MSB]) && (diff[MSB] != p_i[MSB]);
            end
            ALU_AND: r_o = p_i & q_i;
            ALU_XOR: r_o = p_i ^ q_i;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe_cc.sv
// Execute-stage ALU: alu_core followed by a STAGES-deep elastic pipeline with
// a single global advance, plus the architectural ZF/SF/OF register.
module alu_pipe_cc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fn,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_q,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_ofw,
    output logic             out_err,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             busy
);

    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Both sides share one advance signal, so the whole pipe (bubbles too)
    // moves or holds together; the output side never drops valid unasked.
    logic             adv;
    logic             retire;

    logic [WIDTH-1:0] core_r;
    logic             core_ofw;
    logic             core_err;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] ofw_q, ofw_d;
    logic [STAGES-1:0] err_q, err_d;
    logic [STAGES-1:0] sc_q,  sc_d;
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    cc_t               cc_q, cc_d;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .fn_i (in_fn),
        .p_i  (in_p),
        .q_i  (in_q),
        .r_o  (core_r),
        .ofw_o(core_ofw),
        .err_o(core_err)
    );

    assign adv      = !vld_q[LAST] || out_ready;
    assign in_ready = adv;
    assign retire   = vld_q[LAST] && out_ready;

    always_comb begin
        vld_d = vld_q;
        ofw_d = ofw_q;
        err_d = err_q;
        sc_d  = sc_q;
        r_d   = r_q;
        if (adv) begin
            // Bubbles carry zeroed payload so an idle output never shows stale data.
            vld_d[0] = in_valid;
            r_d[0]   = in_valid ? core_r : '0;
            ofw_d[0] = in_valid && core_ofw;
            err_d[0] = in_valid && core_err;
            sc_d[0]  = in_valid && in_set_cc && !core_err;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                r_d[s]   = r_q[s-1];
                ofw_d[s] = ofw_q[s-1];
                err_d[s] = err_q[s-1];
                sc_d[s]  = sc_q[s-1];
            end
        end
    end

    always_comb begin
        cc_d = cc_q;
        if (retire && sc_q[LAST]) begin
            cc_d.zf = (r_q[LAST] == '0);
            cc_d.sf = r_q[LAST][MSB];
            cc_d.of = ofw_q[LAST];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            ofw_q <= '0;
            err_q <= '0;
            sc_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_q[s] <= '0;
            end
            cc_q  <= CC_RST;
        end else begin
            vld_q <= vld_d;
            ofw_q <= ofw_d;
            err_q <= err_d;
            sc_q  <= sc_d;
            for (int s = 0; s < STAGES; s++) begin
                r_q[s] <= r_d[s];
            end
            cc_q  <= cc_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_r     = r_q[LAST];
    assign out_ofw   = ofw_q[LAST];
    assign out_err   = err_q[LAST];
    assign busy      = |vld_q;
    assign cc_zf     = cc_q.zf;
    assign cc_sf     = cc_q.sf;
    assign cc_of     = cc_q.of;

endmodule

// File: tb/tb_alu_pipe_cc.sv
// Bench for alu_pipe_cc: a 64-bit/2-stage instance checked every cycle against
// a queue-based behavioural model, and an 8-bit/1-stage instance with directed checks.
module tb_alu_pipe_cc;
    import alu_pkg::*;

    localparam int W  = 64;
    localparam int ST = 2;
    localparam int SW = 8;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic         rst, in_valid, in_set_cc, out_ready;
    logic [2:0]   in_fn;
    logic [W-1:0] in_p, in_q;
    logic         in_ready, out_valid, out_ofw, out_err, cc_zf, cc_sf, cc_of, busy;
    logic [W-1:0] out_r;

    alu_pipe_cc #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fn(in_fn), .in_p(in_p), .in_q(in_q), .in_set_cc(in_set_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_ofw(out_ofw), .out_err(out_err), .cc_zf(cc_zf), .cc_sf(cc_sf),
        .cc_of(cc_of), .busy(busy)
    );

    // ---------------- small instance ----------------
    logic          s_rst, s_in_valid, s_in_set_cc, s_out_ready;
    logic [2:0]    s_in_fn;
    logic [SW-1:0] s_in_p, s_in_q;
    logic          s_in_ready, s_out_valid, s_out_ofw, s_out_err, s_cc_zf, s_cc_sf, s_cc_of, s_busy;
    logic [SW-1:0] s_out_r;

    alu_pipe_cc #(.WIDTH(SW), .STAGES(1)) dut_s (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_fn(s_in_fn), .in_p(s_in_p), .in_q(s_in_q), .in_set_cc(s_in_set_cc),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_r(s_out_r),
        .out_ofw(s_out_ofw), .out_err(s_out_err), .cc_zf(s_cc_zf), .cc_sf(s_cc_sf),
        .cc_of(s_cc_of), .busy(s_busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Each accepted op, with its expected result and how many advances it has seen.
    typedef struct {
        logic [W-1:0] r;
        logic         ofw;
        logic         err;
        logic         sc;
        int           adv;
    } ent_t;

    ent_t       exp_q[$];
    logic [2:0] cc_m;   // {zf, sf, of}

    function automatic ent_t model_op(input logic [2:0] fn, input logic [W-1:0] p,
                                      input logic [W-1:0] q, input logic sc);
        ent_t e;
        logic signed [W:0] wide;
        e.r = '0; e.ofw = 1'b0; e.err = 1'b0; e.sc = sc; e.adv = 0;
        case (fn)
            3'd0: begin
                wide  = $signed({p[W-1], p}) + $signed({q[W-1], q});
                e.r   = wide[W-1:0];
                e.ofw = (wide[W] != wide[W-1]);
            end
            3'd1: begin
                wide  = $signed({p[W-1], p}) - $signed({q[W-1], q});
                e.r   = wide[W-1:0];
                e.ofw = (wide[W] != wide[W-1]);
            end
            3'd2: e.r = p & q;
            3'd3: e.r = p ^ q;
            default: begin
                e.err = 1'b1;
                e.sc  = 1'b0;
            end
        endcase
        return e;
    endfunction

    // One clock of the main instance: drive, compare against the model, advance the model.
    task automatic cycle(input logic r_v, input logic v, input logic [2:0] fn,
                         input logic [W-1:0] p, input logic [W-1:0] q,
                         input logic sc, input logic ordy);
        ent_t e;
        bit   front;
        rst = r_v; in_valid = v; in_fn = fn; in_p = p; in_q = q;
        in_set_cc = sc; out_ready = ordy;
        #1;
        front = (exp_q.size() > 0) && (exp_q[0].adv == ST);
        check("out_valid", out_valid, front);
        check("in_ready", in_ready, !front || ordy);
        check("busy", busy, exp_q.size() > 0);
        check("cc", {cc_zf, cc_sf, cc_of}, cc_m);
        if (front) begin
            check("out_r", out_r, exp_q[0].r);
            check("out_ofw", out_ofw, exp_q[0].ofw);
            check("out_err", out_err, exp_q[0].err);
        end
        if (r_v) begin
            exp_q.delete();
            cc_m = 3'b100;
        end else if (!front || ordy) begin
            if (front) begin
                e = exp_q.pop_front();
                if (e.sc) cc_m = {(e.r == '0), e.r[W-1], e.ofw};
            end
            foreach (exp_q[i]) exp_q[i].adv = exp_q[i].adv + 1;
            if (v) begin
                e = model_op(fn, p, q, sc);
                e.adv = 1;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] fn, input logic [W-1:0] p, input logic [W-1:0] q,
                      input logic sc);
        cycle(1'b0, 1'b1, fn, p, q, sc, 1'b1);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, ordy);
    endtask

    task automatic s_drive(input logic r_v, input logic v, input logic [2:0] fn,
                           input logic [SW-1:0] p, input logic [SW-1:0] q,
                           input logic sc, input logic ordy);
        s_rst = r_v; s_in_valid = v; s_in_fn = fn; s_in_p = p; s_in_q = q;
        s_in_set_cc = sc; s_out_ready = ordy;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = {1'b0, {(W-1){1'b1}}};
            2: v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

    initial begin
        ent_t pin;
        // Main instance held in reset while the 8-bit instance runs.
        rst = 1'b1; in_valid = 1'b0; in_fn = 3'd0; in_p = '0; in_q = '0;
        in_set_cc = 1'b0; out_ready = 1'b1;
        s_rst = 1'b1; s_in_valid = 1'b0; s_in_fn = 3'd0; s_in_p = '0; s_in_q = '0;
        s_in_set_cc = 1'b0; s_out_ready = 1'b1;
        @(negedge clk);

        // Model pins: literal results computed by hand.
        pin = model_op(3'd0, 64'd69, 64'd96, 1'b1);
        check("pin_add", pin.r, 64'd165);
        pin = model_op(3'd1, 64'd6, 64'd9, 1'b1);
        check("pin_sub", pin.r, 64'hFFFF_FFFF_FFFF_FFFD);
        pin = model_op(3'd0, MAXP, 64'd1, 1'b1);
        check("pin_add_ofw", {pin.ofw, pin.r}, {1'b1, MINN});
        pin = model_op(3'd5, 64'd3, 64'd4, 1'b1);
        check("pin_illegal", {pin.err, pin.sc, pin.r}, {1'b1, 1'b0, 64'd0});

        // ---------------- 8-bit, 1-stage instance ----------------
        s_drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        s_drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        check("s_rst_valid", s_out_valid, 1'b0);
        check("s_rst_busy", s_busy, 1'b0);
        check("s_rst_cc", {s_cc_zf, s_cc_sf, s_cc_of}, 3'b100);
        check("s_rst_out", {s_out_r, s_out_ofw, s_out_err}, 10'd0);
        s_drive(1'b0, 1'b1, 3'd0, 8'd127, 8'd1, 1'b1, 1'b1);
        check("s_ovf_valid", s_out_valid, 1'b1);
        check("s_ovf_r", s_out_r, 8'h80);
        check("s_ovf_ofw", s_out_ofw, 1'b1);
        s_drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        check("s_ovf_cc", {s_cc_zf, s_cc_sf, s_cc_of}, 3'b011);
        s_drive(1'b0, 1'b1, 3'd0, 8'd5, 8'd5, 1'b1, 1'b0);
        s_drive(1'b0, 1'b1, 3'd1, 8'd9, 8'd2, 1'b1, 1'b0);
        check("s_stall_ready", s_in_ready, 1'b0);
        s_drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        check("s_midrst_valid", s_out_valid, 1'b0);
        check("s_midrst_busy", s_busy, 1'b0);
        check("s_midrst_cc", {s_cc_zf, s_cc_sf, s_cc_of}, 3'b100);
        s_drive(1'b0, 1'b1, 3'd0, 8'd67, 8'd9, 1'b0, 1'b1);
        check("s_after_rst_r", s_out_r, 8'd76);
        s_drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1);

        // ---------------- main instance ----------------
        exp_q.delete();
        cc_m = 3'b100;
        rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_out", {out_r, out_ofw, out_err}, 66'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
        @(negedge clk);

        op(3'd0, 64'd69, 64'd96, 1'b1);
        check("lat_early", out_valid, 1'b0);
        idle(1'b1);
        check("lat_valid", out_valid, 1'b1);
        check("add_r", out_r, 64'd165);
        check("add_ofw", out_ofw, 1'b0);
        idle(1'b1);
        check("add_cc", {cc_zf, cc_sf, cc_of}, 3'b000);

        op(3'd1, 64'd6, 64'd9, 1'b1);
        op(3'd2, 64'd4, 64'd456, 1'b1);
        op(3'd3, 64'd49, 64'd4, 1'b1);
        check("sub_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
        check("and_r", out_r, 64'd0);
        idle(1'b1);
        check("and_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
        check("xor_r", out_r, 64'd53);
        idle(1'b1);
        check("xor_cc", {cc_zf, cc_sf, cc_of}, 3'b000);

        op(3'd0, MAXP, 64'd1, 1'b1);
        idle(1'b1);
        check("add_ovf_r", out_r, MINN);
        check("add_ovf_ofw", out_ofw, 1'b1);
        idle(1'b1);
        check("add_ovf_cc", {cc_zf, cc_sf, cc_of}, 3'b011);
        op(3'd1, MINN, 64'd1, 1'b1);
        idle(1'b1);
        check("sub_ovf_r", out_r, MAXP);
        check("sub_ovf_ofw", out_ofw, 1'b1);
        idle(1'b1);

        op(3'd1, 64'd6, 64'd9, 1'b1);
        idle(1'b1);
        idle(1'b1);
        op(3'd5, 64'd3, 64'd4, 1'b1);
        idle(1'b1);
        check("ill_out", {out_err, out_ofw, out_r}, {1'b1, 1'b0, 64'd0});
        idle(1'b1);
        check("ill_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
        op(3'd5, 64'd3, 64'd4, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("ill_nosc_cc", {cc_zf, cc_sf, cc_of}, 3'b010);

        // Backpressure: fill the pipe, stall for five cycles, then drain.
        cycle(1'b0, 1'b1, 3'd0, 64'd10, 64'd20, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 3'd1, 64'd100, 64'd1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'd3, 64'd7, 64'd7, 1'b1, 1'b0);
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_r", out_r, 64'd30);
        check("bp_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
        @(negedge clk);
        idle(1'b1);
        check("bp_second_r", out_r, 64'd99);
        idle(1'b1);
        idle(1'b1);

        // Reset with two operations in flight.
        op(3'd0, 64'd1, 64'd2, 1'b1);
        op(3'd0, 64'd3, 64'd4, 1'b1);
        cycle(1'b1, 1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
        op(3'd0, 64'd67, 64'd9, 1'b0);
        idle(1'b1);
        check("after_rst_r", out_r, 64'd76);
        idle(1'b1);

        // Randomised traffic with backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)),
                  rand_operand(), rand_operand(),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < ST + 2; i++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
